// File: rtl/vision_pkg.sv
// Shared types and helpers for the RTL-Vision filter pipeline.
// Holds the position-counter width and the effective-line-width clamp.
package vision_pkg;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Window of the default 3x3, 8-bit configuration: [row][col][bit].
    typedef logic [2:0][2:0][7:0] win3x3_t;

    // A runtime width of 0, or one beyond the memory depth, means "use the full depth".
    function automatic logic [CNT_W-1:0] clamp_width(input logic [CNT_W-1:0] w,
                                                     input int unsigned     max_w);
        if (w == '0 || 32'(w) > max_w) begin
            return CNT_W'(max_w);
        end
        return w;
    endfunction

    function automatic int unsigned window_bits(input int unsigned k, input int unsigned dw);
        return k * k * dw;
    endfunction

endpackage

// File: rtl/line_ram.sv
// Single-port line memory with read-before-write: rdata shows the old word at addr
// while a write to the same addr lands on the clock edge.
module line_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/line_buffer.sv
// KxK sliding-window generator over a raster pixel stream using K-1 cascaded line memories.
// Optional SVA checks are compiled in when LINE_BUFFER_ASSERT_EN is defined.
module line_buffer
    import vision_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int IMG_WIDTH   = 8,
    parameter int KERNEL_SIZE = 3
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic                                                   pixel_valid,
    input  logic [DATA_WIDTH-1:0]                                  pixel_data,
    output logic                                                   window_valid,
    output logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][DATA_WIDTH-1:0] window_data,
    input  logic [15:0]                                            img_width,
    input  logic                                                   frame_start
);

    localparam int K  = KERNEL_SIZE;
    localparam int AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [CNT_W-1:0] K_M1 = CNT_W'(K - 1);

    typedef logic [K-1:0][K-1:0][DATA_WIDTH-1:0] win_t;

    logic [CNT_W-1:0] col_q, col_d, row_q, row_d;
    logic [CNT_W-1:0] col_cur, row_cur, weff;
    logic             valid_q, valid_d;
    win_t             win_q, win_d;

    logic [DATA_WIDTH-1:0] ram_wr [K-1];
    logic [DATA_WIDTH-1:0] ram_rd [K-1];

    assign weff = clamp_width(img_width, IMG_WIDTH);

    // frame_start restarts the frame at this very pixel, so counters are cleared before use.
    assign col_cur = frame_start ? '0 : col_q;
    assign row_cur = frame_start ? '0 : row_q;

    // Cascade: mem0 takes the new pixel, mem(i) takes what mem(i-1) held one line earlier.
    for (genvar g = 0; g < K - 1; g++) begin : g_line
        if (g == 0) begin : g_first
            assign ram_wr[g] = pixel_data;
        end else begin : g_next
            assign ram_wr[g] = ram_rd[g-1];
        end

        line_ram #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (IMG_WIDTH),
            .AW         (AW)
        ) u_ram (
            .clk   (clk),
            .we    (pixel_valid & ~rst),
            .addr  (col_cur[AW-1:0]),
            .wdata (ram_wr[g]),
            .rdata (ram_rd[g])
        );
    end

    always_comb begin
        col_d   = col_cur;
        row_d   = row_cur;
        valid_d = 1'b0;
        if (pixel_valid) begin
            valid_d = (row_cur >= K_M1) && (col_cur >= K_M1);
            if (col_cur >= weff - 1'b1) begin
                col_d = '0;
                row_d = (row_cur == CNT_MAX) ? row_cur : row_cur + 1'b1;
            end else begin
                col_d = col_cur + 1'b1;
            end
        end
    end

    // Row 0 of the new column is the oldest line, fed by the last memory in the cascade.
    always_comb begin
        win_d = win_q;
        if (pixel_valid) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
            end
            for (int r = 0; r < K - 1; r++) begin
                win_d[r][K-1] = ram_rd[K-2-r];
            end
            win_d[K-1][K-1] = pixel_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            win_q   <= '0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= valid_d;
            win_q   <= win_d;
        end
    end

    assign window_valid = valid_q;
    assign window_data  = win_q;

`ifdef LINE_BUFFER_ASSERT_EN
    a_full_window: assert property (@(posedge clk) disable iff (rst)
        window_valid |-> $past(pixel_valid && row_cur >= K_M1 && col_cur >= K_M1));

    a_one_per_pixel: assert property (@(posedge clk) disable iff (rst)
        (window_valid && $past(window_valid)) |-> ($past(pixel_valid) && $past(pixel_valid, 2)));

    a_width_stable: assert property (@(posedge clk) disable iff (rst)
        !frame_start |-> $stable(img_width));
`else
    // Assertions are not part of the default build.
`endif

endmodule

// File: tb/tb_line_buffer.sv
// Directed bench for line_buffer: an image-level reference model plus literal window checks.
module tb_line_buffer;

    localparam int DW = 8;
    localparam int IW = 8;
    localparam int K  = 3;

    logic                         clk = 1'b0;
    logic                         rst = 1'b1;
    logic                         pixel_valid = 1'b0;
    logic [DW-1:0]                pixel_data = '0;
    logic                         window_valid;
    logic [K-1:0][K-1:0][DW-1:0]  window_data;
    logic [15:0]                  img_width = 16'd0;
    logic                         frame_start = 1'b0;

    line_buffer #(.DATA_WIDTH(DW), .IMG_WIDTH(IW), .KERNEL_SIZE(K)) dut (
        .clk          (clk),
        .rst          (rst),
        .pixel_valid  (pixel_valid),
        .pixel_data   (pixel_data),
        .window_valid (window_valid),
        .window_data  (window_data),
        .img_width    (img_width),
        .frame_start  (frame_start)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Window whose top-left pixel is t in a ramp image of line length w.
    function automatic logic [71:0] mk3(input int t, input int w);
        logic [2:0][2:0][7:0] x;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                x[r][c] = 8'(t + r * w + c);
        return x;
    endfunction

    function automatic int eff_w(input logic [15:0] w);
        if (w == 16'd0 || int'(w) > IW) return IW;
        return int'(w);
    endfunction

    // Reference model: remembers the frame as a 2-D image and cuts windows out of it.
    logic [DW-1:0] img [64][16];
    int            m_row = 0, m_col = 0;
    logic          exp_valid = 1'b0;
    logic [71:0]   exp_data = '0;
    logic          known = 1'b0;
    logic          started = 1'b0;
    int            acc = 0;

    always @(posedge clk) begin
        logic [2:0][2:0][7:0] tmp;
        if (rst) begin
            m_row = 0; m_col = 0;
            exp_valid = 1'b0; exp_data = '0;
            known = 1'b1; started = 1'b1;
        end else begin
            exp_valid = 1'b0;
            if (frame_start) begin
                m_row = 0; m_col = 0;
            end
            if (pixel_valid) begin
                acc++;
                img[m_row % 64][m_col] = pixel_data;
                if (m_row >= K - 1 && m_col >= K - 1) begin
                    for (int r = 0; r < K; r++)
                        for (int c = 0; c < K; c++)
                            tmp[r][c] = img[(m_row - K + 1 + r) % 64][m_col - K + 1 + c];
                    exp_data  = tmp;
                    exp_valid = 1'b1;
                    known     = 1'b1;
                end else begin
                    known = 1'b0;
                end
                m_col++;
                if (m_col >= eff_w(img_width)) begin
                    m_col = 0;
                    m_row++;
                end
            end
        end
    end

    logic [71:0] capq [$];
    int          accq [$];

    always @(negedge clk) begin
        if (started) begin
            check("valid", 72'(window_valid), 72'(exp_valid));
            if (known) check("data", window_data, exp_data);
            if (window_valid) begin
                capq.push_back(window_data);
                accq.push_back(acc);
            end
        end
    end

    function automatic logic [71:0] capw(input int k);
        if (k < capq.size()) return capq[k];
        return '1;
    endfunction

    function automatic int capa(input int k, input int base);
        if (k < accq.size()) return accq[k] - base;
        return -1;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            pixel_valid = 1'b0;
            frame_start = 1'b0;
        end
    endtask

    task automatic pix(input int v);
        @(negedge clk);
        pixel_valid = 1'b1;
        frame_start = 1'b0;
        pixel_data  = 8'(v);
    endtask

    task automatic new_frame(input int w);
        @(negedge clk);
        pixel_valid = 1'b0;
        frame_start = 1'b1;
        img_width   = 16'(w);
        idle(1);
    endtask

    task automatic ramp(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
            pix(i);
        end
        idle(3);
    endtask

    int base;

    initial begin
        // Reset held for five cycles
        rst = 1'b1;
        idle(5);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", 72'(window_valid), 72'd0);
        check("rst_data", window_data, 72'd0);
        idle(4);
        check("no_win_before_pixels", 72'(capq.size()), 72'd0);

        // 8x8 ramp, img_width=0 means full depth
        new_frame(0);
        capq.delete(); accq.delete(); base = acc;
        ramp(64, 1'b0);
        check("ramp_count", 72'(capq.size()), 72'd36);
        check("ramp_first", capw(0), mk3(0, 8));
        check("ramp_first_lat", 72'(capa(0, base)), 72'd19);
        check("ramp_row2_last_pix", 72'(capa(5, base)), 72'd24);
        check("ramp_row3_first", capw(6), mk3(8, 8));
        check("ramp_row3_first_pix", 72'(capa(6, base)), 72'd27);
        check("ramp_last", capw(35), mk3(45, 8));
        check("ramp_last_pix", 72'(capa(35, base)), 72'd64);

        // Same ramp with random gaps
        new_frame(8);
        capq.delete(); accq.delete();
        ramp(64, 1'b1);
        check("gap_count", 72'(capq.size()), 72'd36);
        for (int k = 0; k < 36; k++)
            check($sformatf("gap_win%0d", k), capw(k), mk3((k / 6) * 8 + (k % 6), 8));

        // 5x5 ramp, frame_start coinciding with pixel 0
        idle(1);
        capq.delete(); accq.delete(); base = acc;
        @(negedge clk);
        img_width = 16'd5; frame_start = 1'b1; pixel_valid = 1'b1; pixel_data = 8'd0;
        for (int i = 1; i < 25; i++) pix(i);
        idle(3);
        check("w5_count", 72'(capq.size()), 72'd9);
        check("w5_first", capw(0), mk3(0, 5));
        check("w5_first_pix", 72'(capa(0, base)), 72'd13);
        check("w5_last", capw(8), mk3(12, 5));

        // Mid-frame restart after pixel 30; width 9 is clamped to 8
        new_frame(9);
        capq.delete(); accq.delete();
        ramp(31, 1'b0);
        check("pre_restart_count", 72'(capq.size()), 72'd11);
        new_frame(9);
        capq.delete(); accq.delete(); base = acc;
        ramp(19, 1'b0);
        check("restart_count", 72'(capq.size()), 72'd1);
        check("restart_win", capw(0), mk3(0, 8));
        check("restart_pix", 72'(capa(0, base)), 72'd19);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
